// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, RX FSM states and the baud divider helper.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK_WAIT
  } rx_state_e;

  // Zero means the clock is too slow for the requested rate; callers must reject it.
  function automatic int clks_per_tick(input int clk_freq, input int baud_rate, input int oversample);
    return clk_freq / (baud_rate * oversample);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running oversample tick divider; clear realigns the phase to a line edge.
module uart_baud_tick #(
  parameter int CLKS_PER_TICK = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int W = $clog2(CLKS_PER_TICK + 1);
  localparam logic [W-1:0] LAST = W'(CLKS_PER_TICK - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clear)   cnt <= '0;
    else if (cnt == LAST) cnt <= '0;
    else                  cnt <= cnt + 1'b1;
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: mid-bit sampling, start glitch rejection, parity/stop
// checking, break suppression and a single-entry valid/ready output register.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 1843200,
  parameter int BAUD_RATE  = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CLKS_PER_TICK = clks_per_tick(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] MID_T  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] LAST_T = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_D = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] LAST_S = BW'(STOP_BITS - 1);

  if (CLKS_PER_TICK == 0) begin : g_cfg_err
    $fatal(1, "uart_rx_os: CLK_FREQ too low for BAUD_RATE*OVERSAMPLE");
  end

  logic [1:0] sync_q;
  logic       rx_s;

  always_ff @(posedge clk) begin
    if (reset) sync_q <= 2'b11;
    else       sync_q <= {sync_q[0], rx_in};
  end
  assign rx_s = sync_q[1];

  logic tick, clr;

  uart_baud_tick #(.CLKS_PER_TICK(CLKS_PER_TICK)) u_tick (
    .clk   (clk),
    .reset (reset),
    .clear (clr),
    .tick  (tick)
  );

  rx_state_e            state, state_n;
  logic [TW-1:0]        tick_cnt, tick_cnt_n;
  logic [BW-1:0]        bit_cnt, bit_cnt_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic                 par_err, par_err_n;
  logic                 stop_err, stop_err_n;
  logic                 deliver, deliver_ferr;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      par_err  <= 1'b0;
      stop_err <= 1'b0;
    end else begin
      state    <= state_n;
      tick_cnt <= tick_cnt_n;
      bit_cnt  <= bit_cnt_n;
      shift    <= shift_n;
      par_err  <= par_err_n;
      stop_err <= stop_err_n;
    end
  end

  always_comb begin
    state_n      = state;
    tick_cnt_n   = tick_cnt;
    bit_cnt_n    = bit_cnt;
    shift_n      = shift;
    par_err_n    = par_err;
    stop_err_n   = stop_err;
    clr          = 1'b0;
    deliver      = 1'b0;
    deliver_ferr = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!rx_s) begin
          state_n    = ST_START;
          tick_cnt_n = '0;
          clr        = 1'b1;
        end
      end
      ST_START: begin
        if (tick) begin
          if (tick_cnt == MID_T) begin
            tick_cnt_n = '0;
            if (rx_s) begin
              state_n = ST_IDLE;
            end else begin
              state_n    = ST_DATA;
              bit_cnt_n  = '0;
              par_err_n  = 1'b0;
              stop_err_n = 1'b0;
            end
          end else begin
            tick_cnt_n = tick_cnt + 1'b1;
          end
        end
      end
      ST_DATA, ST_PARITY, ST_STOP: begin
        if (tick) begin
          if (tick_cnt != LAST_T) begin
            tick_cnt_n = tick_cnt + 1'b1;
          end else begin
            tick_cnt_n = '0;
            if (state == ST_DATA) begin
              shift_n = {rx_s, shift[DATA_BITS-1:1]};
              if (bit_cnt == LAST_D) begin
                bit_cnt_n = '0;
                state_n   = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
              end else begin
                bit_cnt_n = bit_cnt + 1'b1;
              end
            end else if (state == ST_PARITY) begin
              // Odd mode expects the XOR over data+parity to be 1, even mode 0.
              par_err_n = (^{shift, rx_s}) ^ (PARITY == PARITY_ODD);
              state_n   = ST_STOP;
            end else begin
              stop_err_n = stop_err | ~rx_s;
              if (bit_cnt == LAST_S) begin
                deliver      = 1'b1;
                deliver_ferr = stop_err | ~rx_s;
                state_n      = deliver_ferr ? ST_BREAK_WAIT : ST_IDLE;
              end else begin
                bit_cnt_n = bit_cnt + 1'b1;
              end
            end
          end
        end
      end
      ST_BREAK_WAIT: begin
        if (rx_s) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign busy = (state != ST_IDLE);

  // A handshake in the same cycle frees the slot, so a new frame can load without overrun.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (data_valid && data_ready) begin
        data_valid <= 1'b0;
        parity_err <= 1'b0;
        frame_err  <= 1'b0;
      end
      if (deliver) begin
        if (!data_valid || data_ready) begin
          data_out   <= shift;
          parity_err <= par_err;
          frame_err  <= deliver_ferr;
          data_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/uart_rx_os.md
Name: uart_rx_os

Overview:
Parametrised, oversampling UART receiver; the next generation of the team's fixed-format RX.
- Adds a baud-tick generator, input synchroniser, mid-bit sampling and start-bit glitch rejection.
- Adds optional parity, 1 or 2 stop bits, error flags and a valid/ready output handshake.
- Sits between the pad-side rx line and the byte-stream consumer (FIFO or CSR block).

Parameters:
CLK_FREQ, 1843200, system clock frequency in Hz.
BAUD_RATE, 115200, line rate in bit/s.
OVERSAMPLE, 16, ticks per bit; must be an even number, 8 or more.
DATA_BITS, 8, payload width; legal range 5..9.
PARITY, 0, parity mode: 0 none, 1 odd, 2 even.
STOP_BITS, 1, number of stop bits: 1 or 2.

Ports:
clk  in  1  system clock.
reset  in  1  synchronous, active-high reset.
rx_in  in  1  asynchronous serial line; idles high.
data_out  out  DATA_BITS  received word, LSB first on the wire.
data_valid  out  1  data_out, parity_err and frame_err are valid.
data_ready  in  1  consumer accepts the word; transfer occurs when data_valid and data_ready are both 1.
parity_err  out  1  parity mismatch on the held word.
frame_err  out  1  a stop bit was sampled low on the held word.
overrun  out  1  one-cycle pulse when a completed frame is dropped.
busy  out  1  high in every state except IDLE.

Behaviour:
Interface: reset is reset, synchronous, active-high; clock is clk.

Reset values:
- All outputs 0.
- Synchroniser flops reset to 1.
- FSM goes to IDLE; divider and counters go to 0.

Input synchroniser:
- 2-FF synchroniser on rx_in. All logic uses the synchronised signal rx_s.

Baud tick:
- Divider of CLKS_PER_TICK = CLK_FREQ/(BAUD_RATE*OVERSAMPLE) cycles, minimum 1.
- tick is high one cycle per period.
- Divider free-runs, except it is cleared on start-edge detection so bit alignment is re-established every frame.

FSM states: IDLE, START, DATA, PARITY, STOP, BREAK_WAIT.
- IDLE: when rx_s is 0, go to START and clear the tick counter.
- START: at tick count OVERSAMPLE/2-1 (mid-start-bit), sample rx_s.
  - If rx_s is 1: glitch; return to IDLE. No flags, no output.
  - If rx_s is 0: go to DATA with the bit counter at 0.
- DATA:
  - Sample every OVERSAMPLE ticks thereafter, at mid-bit.
  - Shift LSB first into the shift register.
  - After DATA_BITS samples, go to PARITY if PARITY != 0, else go to STOP.
- PARITY:
  - Sample one bit.
  - Error if XOR of the data bits and the parity bit is 0 for odd mode, or 1 for even mode.
- STOP:
  - Sample STOP_BITS bits; a low sample on any of them sets the frame error.
  - On the clock after the final stop sample, deliver the frame.
  - With no frame error, go to IDLE.
  - With a frame error, go to BREAK_WAIT.
- BREAK_WAIT: stay until rx_s is 1, then go to IDLE. This prevents a break condition from being decoded as repeated 0x00 frames.

Output register:
- On delivery with data_valid=0:
  - Load data_out, parity_err and frame_err.
  - Set data_valid=1.
- data_valid, data_out and the flags hold until the handshake.
- After the handshake, data_valid=0 next cycle unless a new frame is delivered in that same cycle.
- Delivery while data_valid=1 and data_ready=0:
  - The new frame is dropped.
  - The held word is unchanged.
  - overrun pulses high for exactly 1 cycle.
- Delivery in the same cycle as the handshake: the new word loads, data_valid stays 1, no overrun.
- Frames with errors are still delivered, with their flags set. Flags never assert while data_valid=0.

Latency:
- data_valid rises 1 clk after the final stop-bit sample.
- That is nominally (1+DATA_BITS+P+STOP_BITS-0.5) bit times plus 2 clk (synchroniser) plus 1 clk after the falling edge. P is 1 if parity is enabled, else 0.

Reset mid-frame: aborts immediately; the partial word is discarded and data_valid is cleared.

Arithmetic:
- Tick counter width: $clog2(OVERSAMPLE).
- Bit counter width: $clog2(DATA_BITS+1).
- Divider width: $clog2(CLKS_PER_TICK+1).
- Elaboration-time check: if CLKS_PER_TICK is 0, raise a fatal error.

Decomposition:
Package uart_pkg contains:
- PARITY_NONE/ODD/EVEN constants.
- The FSM state enum.
- A clks_per_tick function, shared with the TX.

Sub-module uart_baud_tick contains:
- The divider with a clear input.
- The tick output.
- Reusable by uart_tx.

The synchroniser stays inline in uart_rx_os.

Test Plan:
All scenarios use the defaults (tick every clk, 16 clk per bit) unless stated.
- Frame 0xA5, 8N1, data_ready=1 -> data_valid for 1 cycle, data_out=0xA5, parity_err=0, frame_err=0; rise about 9.5*16+3 clk after the start edge.
- PARITY=2: send 0x37 with parity bit 1 -> parity_err=0. Resend with parity bit 0 -> data_out=0x37, parity_err=1.
- Frame 0x3C with stop bit 0, line held low 40 clk, then high, then frame 0x11:
  - First delivery: 0x3C with frame_err=1.
  - No spurious 0x00 delivery.
  - Next delivery: 0x11 with frame_err=0.
- Low glitch of 5 clk on an idle line -> busy rises, then returns to 0 about 8 clk later; no data_valid.
- data_ready=0, back-to-back frames 0x11 and 0x22 -> 0x11 held with data_valid=1, overrun pulses once; assert data_ready -> 0x11 is transferred and 0x22 is never seen.
- Assert reset at mid-bit 4 of frame 0x5A, then release it and send 0xC3 -> all outputs 0 during reset; next delivery is exactly 0xC3.
